// File: rtl/management_bus_initiator.sv
// -----------------------------------------------------------------------------
// management_bus_initiator
//
// Turns framed bytes from a serial device PHY into register bus accesses.
// A frame is started by evt_start. Its first two bytes carry a read flag
// (bit 7 of the first byte) and a 15-bit register address. The remaining
// bytes are either written to consecutive addresses or, for a read frame,
// consecutive registers are fetched and presented to the PHY one byte at a
// time.
//
// Ports
//   clk            core management clock (the only clock)
//   rst            synchronous active-high reset
//   evt_start      frame start pulse (chip select asserted)
//   evt_stop       frame end pulse (chip select deasserted)
//   rx_data_valid  received byte strobe
//   rx_data[7:0]   received byte
//   tx_data_valid  tx_data holds a byte for the PHY to shift out
//   tx_data[7:0]   byte to shift out next
//   tx_byte_done   PHY has finished shifting the presented byte
//   rd_en          single-cycle register read request
//   rd_addr[15:0]  read address, bit 15 always 0
//   rd_valid       read response strobe
//   rd_data[7:0]   read response data
//   wr_en          single-cycle register write strobe
//   wr_addr[15:0]  write address, bit 15 always 0
//   wr_data[7:0]   write data
//   busy           high whenever a frame is in progress (state not IDLE)
//
// Parameter
//   RD_TIMEOUT     cycles to wait for rd_valid before substituting 0x00
// -----------------------------------------------------------------------------
module management_bus_initiator #(
   parameter int unsigned RD_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        evt_start,
   input  logic        evt_stop,
   input  logic        rx_data_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_data_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_byte_done,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   input  logic        rd_valid,
   input  logic [7:0]  rd_data,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy
);

   localparam int TW = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR_HI,
      ADDR_LO,
      WRITE,
      READ_WAIT,
      READ_HOLD
   } state_e;

   state_e        state_q,    state_d;
   logic [14:0]   addr_q,     addr_d;
   logic          rd_flag_q,  rd_flag_d;
   logic [TW-1:0] timer_q,    timer_d;
   logic          rd_en_q,    rd_en_d;
   logic [15:0]   rd_addr_q,  rd_addr_d;
   logic          wr_en_q,    wr_en_d;
   logic [15:0]   wr_addr_q,  wr_addr_d;
   logic [7:0]    wr_data_q,  wr_data_d;
   logic [7:0]    tx_data_q,  tx_data_d;
   logic          tx_valid_q, tx_valid_d;

   // 15-bit increment: wraps 0x7FFF -> 0x0000 on its own.
   logic [14:0]   addr_inc;
   assign addr_inc = addr_q + 15'd1;

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d    = state_q;
      addr_d     = addr_q;
      rd_flag_d  = rd_flag_q;
      timer_d    = timer_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;

      // Frame events override everything else; start wins over stop so a
      // back-to-back stop/start pair still opens the new frame. Any byte,
      // response or done strobe in the same cycle is dropped.
      if (evt_start) begin
         state_d    = ADDR_HI;
         tx_valid_d = 1'b0;
         timer_d    = '0;
      end else if (evt_stop) begin
         state_d    = IDLE;
         tx_valid_d = 1'b0;
         timer_d    = '0;
      end else begin
         case (state_q)
            ADDR_HI: begin
               if (rx_data_valid) begin
                  rd_flag_d = rx_data[7];
                  addr_d    = {rx_data[6:0], addr_q[7:0]};
                  state_d   = ADDR_LO;
               end
            end
            ADDR_LO: begin
               if (rx_data_valid) begin
                  addr_d = {addr_q[14:8], rx_data};
                  if (rd_flag_q) begin
                     state_d   = READ_WAIT;
                     rd_en_d   = 1'b1;
                     rd_addr_d = {1'b0, addr_q[14:8], rx_data};
                     timer_d   = '0;
                  end else begin
                     state_d = WRITE;
                  end
               end
            end
            WRITE: begin
               if (rx_data_valid) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {1'b0, addr_q};
                  wr_data_d = rx_data;
                  addr_d    = addr_inc;
               end
            end
            READ_WAIT: begin
               // timer_q is 0 in the cycle rd_en is high and counts up from
               // there; reaching RD_TIMEOUT gives up on the responder.
               if (rd_valid) begin
                  tx_data_d  = rd_data;
                  tx_valid_d = 1'b1;
                  state_d    = READ_HOLD;
               end else if (timer_q == TW'(RD_TIMEOUT)) begin
                  tx_data_d  = 8'h00;
                  tx_valid_d = 1'b1;
                  state_d    = READ_HOLD;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            READ_HOLD: begin
               // The next read is only issued once the current byte is
               // consumed, so at most one read is ever outstanding.
               if (tx_byte_done) begin
                  addr_d     = addr_inc;
                  tx_valid_d = 1'b0;
                  rd_en_d    = 1'b1;
                  rd_addr_d  = {1'b0, addr_inc};
                  timer_d    = '0;
                  state_d    = READ_WAIT;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge value of the others.
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rd_flag_q  <= 1'b0;
         timer_q    <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rd_flag_q  <= rd_flag_d;
         timer_q    <= timer_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign rd_en         = rd_en_q;
   assign rd_addr       = rd_addr_q;
   assign wr_en         = wr_en_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign tx_data       = tx_data_q;
   assign tx_data_valid = tx_valid_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_management_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_management_bus_initiator
//
// Self-checking bench for management_bus_initiator. A cycle-by-cycle vector
// table covers a write frame, a read frame, restart and start/stop collision;
// hand-written sequences cover address wrap, stop colliding with a byte,
// read timeout and reset during an outstanding read.
// -----------------------------------------------------------------------------
module tb_management_bus_initiator;

   localparam int unsigned RD_TIMEOUT = 15;

   // Per-vector input controls: {start, stop, rx_valid, tx_byte_done, rd_valid}
   localparam logic [4:0] C_NONE  = 5'b00000;
   localparam logic [4:0] C_START = 5'b10000;
   localparam logic [4:0] C_STOP  = 5'b01000;
   localparam logic [4:0] C_RX    = 5'b00100;
   localparam logic [4:0] C_TBD   = 5'b00010;
   localparam logic [4:0] C_RDV   = 5'b00001;

   localparam int NV = 26;

   logic        clk;
   logic        rst;
   logic        evt_start;
   logic        evt_stop;
   logic        rx_data_valid;
   logic [7:0]  rx_data;
   logic        tx_data_valid;
   logic [7:0]  tx_data;
   logic        tx_byte_done;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int excl_viol = 0;

   typedef struct {
      logic [4:0]  ctl;
      logic [7:0]  din;   // drives both rx_data and rd_data
      logic        busy;
      logic        we;
      logic [15:0] wa;
      logic [7:0]  wd;
      logic        re;
      logic [15:0] ra;
      logic        txv;
      logic [7:0]  tx;
   } vec_t;

   vec_t vecs [NV];

   management_bus_initiator #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
      .clk           (clk),
      .rst           (rst),
      .evt_start     (evt_start),
      .evt_stop      (evt_stop),
      .rx_data_valid (rx_data_valid),
      .rx_data       (rx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data       (tx_data),
      .tx_byte_done  (tx_byte_done),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read and write strobes must never coincide.
   always @(negedge clk) begin
      if (rd_en && wr_en) excl_viol++;
   end

   function automatic vec_t mk(input logic [4:0] ctl, input logic [7:0] din,
                               input logic b, input logic we, input logic [15:0] wa,
                               input logic [7:0] wd, input logic re, input logic [15:0] ra,
                               input logic txv, input logic [7:0] tx);
      vec_t v;
      v.ctl = ctl; v.din = din; v.busy = b; v.we = we; v.wa = wa; v.wd = wd;
      v.re = re; v.ra = ra; v.txv = txv; v.tx = tx;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] ctl, input logic [7:0] din);
      evt_start     = ctl[4];
      evt_stop      = ctl[3];
      rx_data_valid = ctl[2];
      tx_byte_done  = ctl[1];
      rd_valid      = ctl[0];
      rx_data       = din;
      rd_data       = din;
   endtask

   task automatic send(input logic [4:0] ctl, input logic [7:0] din);
      drive(ctl, din);
      tick();
      drive(C_NONE, 8'h00);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"},    busy,          0);
      check({tag, ".wr_en"},   wr_en,         0);
      check({tag, ".wr_addr"}, wr_addr,       0);
      check({tag, ".wr_data"}, wr_data,       0);
      check({tag, ".rd_en"},   rd_en,         0);
      check({tag, ".rd_addr"}, rd_addr,       0);
      check({tag, ".txv"},     tx_data_valid, 0);
      check({tag, ".tx_data"}, tx_data,       0);
   endtask

   initial begin
      int  n_lat;
      bit  got;
      int  rd_pulses;
      int  wr_seen;

      // ---------------- vector table ----------------
      // Write frame 0x00 0x84 0xAA 0xBB
      vecs[0]  = mk(C_START,        8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
      vecs[1]  = mk(C_RX,           8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
      vecs[2]  = mk(C_RX,           8'h84, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
      vecs[3]  = mk(C_RX,           8'hAA, 1'b1, 1'b1, 16'h0084, 8'hAA, 1'b0, 16'h0000, 1'b0, 8'h00);
      vecs[4]  = mk(C_RX,           8'hBB, 1'b1, 1'b1, 16'h0085, 8'hBB, 1'b0, 16'h0000, 1'b0, 8'h00);
      vecs[5]  = mk(C_NONE,         8'h00, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0000, 1'b0, 8'h00);
      vecs[6]  = mk(C_STOP,         8'h00, 1'b0, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0000, 1'b0, 8'h00);
      // Read frame 0x80 0x20, response 0x01, then next read at 0x0021
      vecs[7]  = mk(C_START,        8'h00, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0000, 1'b0, 8'h00);
      vecs[8]  = mk(C_RX,           8'h80, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0000, 1'b0, 8'h00);
      vecs[9]  = mk(C_RX,           8'h20, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b1, 16'h0020, 1'b0, 8'h00);
      vecs[10] = mk(C_RX,           8'h99, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0020, 1'b0, 8'h00);
      vecs[11] = mk(C_RDV,          8'h01, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0020, 1'b1, 8'h01);
      vecs[12] = mk(C_RX,           8'h66, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0020, 1'b1, 8'h01);
      vecs[13] = mk(C_RDV,          8'h55, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0020, 1'b1, 8'h01);
      vecs[14] = mk(C_TBD,          8'h00, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b1, 16'h0021, 1'b0, 8'h01);
      vecs[15] = mk(C_RDV,          8'h5A, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0021, 1'b1, 8'h5A);
      vecs[16] = mk(C_STOP,         8'h00, 1'b0, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0021, 1'b0, 8'h5A);
      // Late response and stray done after stop are ignored
      vecs[17] = mk(C_RDV | C_TBD,  8'h77, 1'b0, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0021, 1'b0, 8'h5A);
      // Restart mid-frame, then write 0x33 at 0x0102
      vecs[18] = mk(C_START,        8'h00, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0021, 1'b0, 8'h5A);
      vecs[19] = mk(C_RX,           8'h00, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0021, 1'b0, 8'h5A);
      vecs[20] = mk(C_START,        8'h00, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0021, 1'b0, 8'h5A);
      vecs[21] = mk(C_RX,           8'h01, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0021, 1'b0, 8'h5A);
      vecs[22] = mk(C_RX,           8'h02, 1'b1, 1'b0, 16'h0085, 8'hBB, 1'b0, 16'h0021, 1'b0, 8'h5A);
      vecs[23] = mk(C_RX,           8'h33, 1'b1, 1'b1, 16'h0102, 8'h33, 1'b0, 16'h0021, 1'b0, 8'h5A);
      // Start and stop together: start wins
      vecs[24] = mk(C_START | C_STOP, 8'h00, 1'b1, 1'b0, 16'h0102, 8'h33, 1'b0, 16'h0021, 1'b0, 8'h5A);
      vecs[25] = mk(C_STOP,         8'h00, 1'b0, 1'b0, 16'h0102, 8'h33, 1'b0, 16'h0021, 1'b0, 8'h5A);

      // ---------------- reset ----------------
      drive(C_NONE, 8'h00);
      rst = 1'b1;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;

      // ---------------- table ----------------
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].ctl, vecs[i].din);
         tick();
         check($sformatf("v%0d.busy", i),    busy,          vecs[i].busy);
         check($sformatf("v%0d.wr_en", i),   wr_en,         vecs[i].we);
         check($sformatf("v%0d.wr_addr", i), wr_addr,       vecs[i].wa);
         check($sformatf("v%0d.wr_data", i), wr_data,       vecs[i].wd);
         check($sformatf("v%0d.rd_en", i),   rd_en,         vecs[i].re);
         check($sformatf("v%0d.rd_addr", i), rd_addr,       vecs[i].ra);
         check($sformatf("v%0d.txv", i),     tx_data_valid, vecs[i].txv);
         check($sformatf("v%0d.tx_data", i), tx_data,       vecs[i].tx);
      end
      drive(C_NONE, 8'h00);

      // ---------------- address wrap 0x7FFF -> 0x0000 ----------------
      send(C_START, 8'h00);
      send(C_RX, 8'h7F);
      send(C_RX, 8'hFF);
      send(C_RX, 8'h11);
      check("wrap1.wr_en",   wr_en,   1);
      check("wrap1.wr_addr", wr_addr, 16'h7FFF);
      check("wrap1.wr_data", wr_data, 8'h11);
      send(C_RX, 8'h22);
      check("wrap2.wr_en",   wr_en,   1);
      check("wrap2.wr_addr", wr_addr, 16'h0000);
      check("wrap2.wr_data", wr_data, 8'h22);
      send(C_STOP, 8'h00);

      // ---------------- stop collides with a byte in WRITE ----------------
      send(C_START, 8'h00);
      send(C_RX, 8'h01);
      send(C_RX, 8'h10);
      send(C_STOP | C_RX, 8'h99);
      check("stoprx.wr_en",   wr_en,   0);
      check("stoprx.busy",    busy,    0);
      check("stoprx.wr_data", wr_data, 8'h22);
      tick();
      check("stoprx.wr_en_after", wr_en, 0);
      send(C_START, 8'h00);
      send(C_RX, 8'h01);
      send(C_RX, 8'h10);
      send(C_RX, 8'h44);
      check("next.wr_en",   wr_en,   1);
      check("next.wr_addr", wr_addr, 16'h0110);
      check("next.wr_data", wr_data, 8'h44);
      send(C_STOP, 8'h00);

      // ---------------- read timeout ----------------
      send(C_START, 8'h00);
      send(C_RX, 8'h80);
      send(C_RX, 8'h30);
      check("to.rd_en",   rd_en,   1);
      check("to.rd_addr", rd_addr, 16'h0030);
      got = 1'b0;
      n_lat = 0;
      rd_pulses = 0;
      wr_seen = 0;
      for (int i = 1; i <= 40 && !got; i++) begin
         // A stray byte while waiting must not become a write.
         if (i == 3) drive(C_RX, 8'hEE);
         tick();
         drive(C_NONE, 8'h00);
         if (rd_en) rd_pulses++;
         if (wr_en) wr_seen++;
         if (tx_data_valid) begin
            got = 1'b1;
            n_lat = i;
         end
      end
      check("to.seen",       got, 1);
      check("to.latency_ok", (n_lat >= RD_TIMEOUT) && (n_lat <= RD_TIMEOUT + 2), 1);
      check("to.tx_data",    tx_data, 8'h00);
      check("to.one_read",   rd_pulses, 0);
      check("to.no_write",   wr_seen, 0);
      tick();
      tick();
      check("to.hold_txv",  tx_data_valid, 1);
      check("to.hold_data", tx_data, 8'h00);
      send(C_TBD, 8'h00);
      check("to.next_rd_en",   rd_en,         1);
      check("to.next_rd_addr", rd_addr,       16'h0031);
      check("to.next_txv",     tx_data_valid, 0);
      send(C_STOP, 8'h00);

      // ---------------- reset during READ_WAIT ----------------
      send(C_START, 8'h00);
      send(C_RX, 8'h80);
      send(C_RX, 8'h40);
      tick();
      tick();
      check("rstrd.busy_before", busy, 1);
      rst = 1'b1;
      tick();
      check_all_zero("rstrd");
      rst = 1'b0;
      send(C_RDV, 8'h66);
      tick();
      check("rstrd.late_txv",  tx_data_valid, 0);
      check("rstrd.late_tx",   tx_data,       0);
      check("rstrd.late_busy", busy,          0);
      check("rstrd.late_rd",   rd_en,         0);

      check("rd_wr_exclusive", excl_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
